// File: rtl/std_cache_pkg.sv
// Shared types and helpers for the adapter arbiter: per-path FSM state and
// round-robin pointer advance.
package std_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } path_state_e;

    function automatic int rr_next(input int cur, input int n);
        return (cur >= n - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/axi_adapter_arb_rr_select.sv
// Round-robin port selector: picks the lowest requesting port at or above
// i_ptr, otherwise wraps to the lowest requesting port overall.
module rr_select #(
    parameter int NUM_PORTS = 2,
    parameter int PW        = 1
)(
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PW-1:0]        i_ptr,
    output logic [PW-1:0]        o_sel
);

    always_comb begin
        o_sel = '0;
        // Descending scans: the last hit wins, so the second pass overrides
        // the wrap-around choice whenever a port at or above i_ptr requests.
        for (int p = NUM_PORTS - 1; p >= 0; p--)
            if (i_req[p]) o_sel = PW'(p);
        for (int p = NUM_PORTS - 1; p >= 0; p--)
            if (i_req[p] && (PW'(p) >= i_ptr)) o_sel = PW'(p);
    end

endmodule

// File: rtl/axi_adapter_arb.sv
// Arbitrates NUM_PORTS cache requesters onto one adapter with independent
// read and write FSMs, one outstanding transaction per path.
module axi_adapter_arb
    import std_cache_pkg::*;
#(
    parameter int  NUM_PORTS    = 2,
    parameter int  DATA_WORDS   = 4,
    parameter int  AXI_ID_WIDTH = 10,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int BW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1
)(
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NUM_PORTS-1:0]                    rd_req_i,
    output logic [NUM_PORTS-1:0]                    rd_gnt_o,
    input  logic [NUM_PORTS-1:0][63:0]              rd_addr_i,
    input  logic [NUM_PORTS-1:0][BW-1:0]            rd_blen_i,
    input  logic [NUM_PORTS-1:0][1:0]               rd_size_i,
    output logic [NUM_PORTS-1:0]                    rd_valid_o,
    output logic [DATA_WORDS-1:0][63:0]             rd_data_o,
    input  logic [NUM_PORTS-1:0]                    wr_req_i,
    output logic [NUM_PORTS-1:0]                    wr_gnt_o,
    input  logic [NUM_PORTS-1:0][63:0]              wr_addr_i,
    input  logic [NUM_PORTS-1:0][DATA_WORDS-1:0][63:0] wr_data_i,
    input  logic [NUM_PORTS-1:0][DATA_WORDS-1:0][7:0]  wr_be_i,
    input  logic [NUM_PORTS-1:0][BW-1:0]            wr_blen_i,
    input  logic [NUM_PORTS-1:0][1:0]               wr_size_i,
    output logic [NUM_PORTS-1:0]                    wr_valid_o,
    output logic                                    ad_rd_req_o,
    input  logic                                    ad_rd_gnt_i,
    output logic [63:0]                             ad_rd_addr_o,
    output logic [BW-1:0]                           ad_rd_blen_o,
    output logic [1:0]                              ad_rd_size_o,
    output logic [AXI_ID_WIDTH-1:0]                 ad_rd_id_o,
    output logic                                    ad_rd_rdy_o,
    input  logic                                    ad_rd_valid_i,
    input  logic [DATA_WORDS-1:0][63:0]             ad_rd_data_i,
    input  logic [AXI_ID_WIDTH-1:0]                 ad_rd_id_i,
    output logic                                    ad_wr_req_o,
    input  logic                                    ad_wr_gnt_i,
    output logic [63:0]                             ad_wr_addr_o,
    output logic [DATA_WORDS-1:0][63:0]             ad_wr_data_o,
    output logic [DATA_WORDS-1:0][7:0]              ad_wr_be_o,
    output logic [BW-1:0]                           ad_wr_blen_o,
    output logic [1:0]                              ad_wr_size_o,
    output logic [AXI_ID_WIDTH-1:0]                 ad_wr_id_o,
    output logic                                    ad_wr_rdy_o,
    input  logic                                    ad_wr_valid_i,
    input  logic [AXI_ID_WIDTH-1:0]                 ad_wr_id_i,
    output logic                                    id_err_o
);

    path_state_e   r_rd_state, r_wr_state;
    logic [PW-1:0] r_rd_sel, r_wr_sel, r_rd_ptr, r_wr_ptr;
    logic [PW-1:0] w_rd_pick, w_wr_pick;
    logic          r_id_err;
    logic          w_rd_id_bad, w_wr_id_bad;

    rr_select #(.NUM_PORTS(NUM_PORTS), .PW(PW)) u_rd_rr (
        .i_req (rd_req_i),
        .i_ptr (r_rd_ptr),
        .o_sel (w_rd_pick)
    );

    rr_select #(.NUM_PORTS(NUM_PORTS), .PW(PW)) u_wr_rr (
        .i_req (wr_req_i),
        .i_ptr (r_wr_ptr),
        .o_sel (w_wr_pick)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_state <= ST_IDLE;
            r_rd_sel   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            case (r_rd_state)
                ST_IDLE: if (|rd_req_i) begin
                    r_rd_sel   <= w_rd_pick;
                    r_rd_state <= ST_REQ;
                end
                ST_REQ: if (ad_rd_gnt_i) begin
                    r_rd_ptr   <= PW'(rr_next(int'(r_rd_sel), NUM_PORTS));
                    r_rd_state <= ST_RESP;
                end
                ST_RESP: if (ad_rd_valid_i) r_rd_state <= ST_IDLE;
                default: r_rd_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_state <= ST_IDLE;
            r_wr_sel   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            case (r_wr_state)
                ST_IDLE: if (|wr_req_i) begin
                    r_wr_sel   <= w_wr_pick;
                    r_wr_state <= ST_REQ;
                end
                ST_REQ: if (ad_wr_gnt_i) begin
                    r_wr_ptr   <= PW'(rr_next(int'(r_wr_sel), NUM_PORTS));
                    r_wr_state <= ST_RESP;
                end
                ST_RESP: if (ad_wr_valid_i) r_wr_state <= ST_IDLE;
                default: r_wr_state <= ST_IDLE;
            endcase
        end
    end

    // The ID flag is sticky; only reset clears it.
    assign w_rd_id_bad = (r_rd_state == ST_RESP) && ad_rd_valid_i &&
                         (ad_rd_id_i != AXI_ID_WIDTH'(r_rd_sel));
    assign w_wr_id_bad = (r_wr_state == ST_RESP) && ad_wr_valid_i &&
                         (ad_wr_id_i != AXI_ID_WIDTH'(r_wr_sel));

    always_ff @(posedge clk_i) begin
        if (rst_i)                           r_id_err <= 1'b0;
        else if (w_rd_id_bad || w_wr_id_bad) r_id_err <= 1'b1;
    end

    assign id_err_o = r_id_err;

    assign ad_rd_req_o  = (r_rd_state == ST_REQ);
    assign ad_rd_rdy_o  = (r_rd_state == ST_RESP);
    assign ad_rd_addr_o = rd_addr_i[r_rd_sel];
    assign ad_rd_blen_o = rd_blen_i[r_rd_sel];
    assign ad_rd_size_o = rd_size_i[r_rd_sel];
    assign ad_rd_id_o   = AXI_ID_WIDTH'(r_rd_sel);
    assign rd_data_o    = ad_rd_data_i;

    assign ad_wr_req_o  = (r_wr_state == ST_REQ);
    assign ad_wr_rdy_o  = (r_wr_state == ST_RESP);
    assign ad_wr_addr_o = wr_addr_i[r_wr_sel];
    assign ad_wr_data_o = wr_data_i[r_wr_sel];
    assign ad_wr_be_o   = wr_be_i[r_wr_sel];
    assign ad_wr_blen_o = wr_blen_i[r_wr_sel];
    assign ad_wr_size_o = wr_size_i[r_wr_sel];
    assign ad_wr_id_o   = AXI_ID_WIDTH'(r_wr_sel);

    always_comb begin
        rd_gnt_o   = '0;
        rd_valid_o = '0;
        wr_gnt_o   = '0;
        wr_valid_o = '0;
        rd_gnt_o[r_rd_sel]   = (r_rd_state == ST_REQ)  && ad_rd_gnt_i;
        rd_valid_o[r_rd_sel] = (r_rd_state == ST_RESP) && ad_rd_valid_i;
        wr_gnt_o[r_wr_sel]   = (r_wr_state == ST_REQ)  && ad_wr_gnt_i;
        wr_valid_o[r_wr_sel] = (r_wr_state == ST_RESP) && ad_wr_valid_i;
    end

endmodule
